jk_pattern_driver: RTL and testbench

- Synthesizable stimulus source for the JK-style `fsm` block (inputs j, k; output out).
- Accepts a target output pattern through a valid/ready handshake and emits one j/k pair per clock so that the fsm's `out` reproduces the pattern bit by bit.
- Reads `out` back and flags any mismatch.
- Replaces hand-written j/k sequences in benches and serves as an on-chip self-test driver.

---
 rtl/jk_pattern_driver.sv | 109 ++++++++++
 tb/tb_jk_pattern_driver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_pattern_driver.sv
// rtl/jk_pattern_driver.sv - drives j/k into a JK-style fsm so its out replays a pattern.
// Reads the fsm out back one cycle later and counts bits that did not land.
module jk_pattern_driver #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pat,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             j,
    output logic             k,
    input  logic             fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_count
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [IW-1:0]    r_idx;
    logic             r_cur;
    logic             r_exp_q;
    logic             r_check_valid;

    logic             w_t;
    logic             w_drive;

    assign w_t     = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
    assign w_drive = (r_state == S_DRIVE);

    // Minimal excitation: never toggle, and leave the flop alone when it already holds t.
    assign j = w_drive & w_t & ~r_cur;
    assign k = w_drive & ~w_t & r_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_idx         <= '0;
            r_cur         <= 1'b0;
            r_exp_q       <= 1'b0;
            r_check_valid <= 1'b0;
            pat_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            mismatch      <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            done <= 1'b0;

            // fb reflects the j/k registered by the fsm at the previous edge.
            if (r_check_valid && (fb != r_exp_q)) begin
                mismatch <= 1'b1;
                if (err_count != 8'd255) begin
                    err_count <= err_count + 8'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (pat_valid && pat_ready) begin
                        r_shreg   <= pat;
                        r_idx     <= '0;
                        mismatch  <= 1'b0;
                        pat_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_cur         <= w_t;
                    r_exp_q       <= w_t;
                    r_check_valid <= 1'b1;
                    r_idx         <= r_idx + IW'(1);
                    if (LSB_FIRST) begin
                        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                    end else begin
                        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    end
                    if (r_idx == IW'(WIDTH - 1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    done          <= 1'b1;
                    r_check_valid <= 1'b0;
                    pat_ready     <= 1'b1;
                    busy          <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// tb/tb_jk_pattern_driver.sv - directed bench for jk_pattern_driver with a JK flop model.
module tb_jk_pattern_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pat0 = 8'h00;
    logic [7:0] pat1 = 8'h00;
    logic       pv0 = 1'b0;
    logic       pv1 = 1'b0;
    logic       stuck = 1'b0;

    logic       pr0, j0, k0, busy0, done0, mm0;
    logic       pr1, j1, k1, busy1, done1, mm1;
    logic [7:0] err0, err1;
    logic       out0, out1;
    logic       fb0;

    int checks = 0;
    int errors = 0;

    assign fb0 = stuck ? 1'b0 : out0;

    always #5 clk = ~clk;

    jk_pattern_driver #(.WIDTH(8), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .pat(pat0), .pat_valid(pv0), .pat_ready(pr0),
        .j(j0), .k(k0), .fb(fb0), .busy(busy0), .done(done0),
        .mismatch(mm0), .err_count(err0)
    );

    jk_pattern_driver #(.WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .pat(pat1), .pat_valid(pv1), .pat_ready(pr1),
        .j(j1), .k(k1), .fb(out1), .busy(busy1), .done(done1),
        .mismatch(mm1), .err_count(err1)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            out0 <= 1'b0;
        end else begin
            case ({j0, k0})
                2'b10:   out0 <= 1'b1;
                2'b01:   out0 <= 1'b0;
                2'b11:   out0 <= ~out0;
                default: out0 <= out0;
            endcase
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            out1 <= 1'b0;
        end else begin
            case ({j1, k1})
                2'b10:   out1 <= 1'b1;
                2'b01:   out1 <= 1'b0;
                2'b11:   out1 <= ~out1;
                default: out1 <= out1;
            endcase
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({pr0, j0, k0, busy0, done0} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_ctrl0 cyc %0d: got %b want 10000", i, {pr0, j0, k0, busy0, done0});
            end
            checks++;
            if (err0 !== 8'd0 || mm0 !== 1'b0 || out0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_stat0 cyc %0d: err=%0d mm=%b out=%b want 0/0/0", i, err0, mm0, out0);
            end
            checks++;
            if ({pr1, j1, k1, busy1, done1} !== 5'b10000 || err1 !== 8'd0) begin
                errors++;
                $display("FAIL reset_dut1 cyc %0d: ctrl=%b err=%0d want 10000/0", i, {pr1, j1, k1, busy1, done1}, err1);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_jk [8];
        logic [7:0] p;
        exp_jk = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
        p = 8'hB2;
        pat0 = p;
        pv0  = 1'b1;
        @(negedge clk);
        // Queue the next pattern now: it must not disturb the one in flight.
        pat0 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({j0, k0} !== exp_jk[i]) begin
                errors++;
                $display("FAIL basic_jk cyc %0d: got %b want %b", i, {j0, k0}, exp_jk[i]);
            end
            if (i > 0) begin
                checks++;
                if (out0 !== p[i-1]) begin
                    errors++;
                    $display("FAIL basic_out cyc %0d: got %b want %b", i, out0, p[i-1]);
                end
            end
            checks++;
            if ({busy0, done0, pr0} !== 3'b100) begin
                errors++;
                $display("FAIL basic_ctrl cyc %0d: got %b want 100", i, {busy0, done0, pr0});
            end
        end
        @(negedge clk);
        checks++;
        if ({j0, k0, busy0, done0, out0} !== 5'b00101) begin
            errors++;
            $display("FAIL basic_drain: got %b want 00101", {j0, k0, busy0, done0, out0});
        end
        @(negedge clk);
        checks++;
        if ({done0, pr0, busy0, mm0} !== 4'b1100 || err0 !== 8'd0) begin
            errors++;
            $display("FAIL basic_done: got %b err=%0d want 1100 err=0", {done0, pr0, busy0, mm0}, err0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({j0, k0} !== ((i == 0) ? 2'b01 : 2'b00) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_jk cyc %0d: jk=%b busy=%b want %b busy=1", i, {j0, k0}, busy0, (i == 0) ? 2'b01 : 2'b00);
            end
            if (i > 0) begin
                checks++;
                if (out0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_out cyc %0d: got %b want 0", i, out0);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({j0, k0, done0, out0} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_drain: got %b want 0000", {j0, k0, done0, out0});
        end
        @(negedge clk);
        checks++;
        if ({done0, pr0, mm0} !== 3'b110 || err0 !== 8'd0) begin
            errors++;
            $display("FAIL b2b_done: got %b err=%0d want 110 err=0", {done0, pr0, mm0}, err0);
        end
    endtask

    task automatic test_stuck_fb();
        stuck = 1'b1;
        pat0  = 8'hFF;
        pv0   = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (err0 !== ((i < 2) ? 8'd0 : 8'(i - 1)) || mm0 !== (i >= 2)) begin
                errors++;
                $display("FAIL stuck_err cyc %0d: err=%0d mm=%b want %0d/%b", i, err0, mm0, (i < 2) ? 0 : i - 1, i >= 2);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || mm0 !== 1'b1 || err0 !== 8'd8) begin
            errors++;
            $display("FAIL stuck_done: done=%b mm=%b err=%0d want 1/1/8", done0, mm0, err0);
        end
        pat0 = 8'h00;
        pv0  = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        checks++;
        if (mm0 !== 1'b0 || err0 !== 8'd8 || {j0, k0} !== 2'b01) begin
            errors++;
            $display("FAIL stuck_clear: mm=%b err=%0d jk=%b want 0/8/01", mm0, err0, {j0, k0});
        end
        repeat (9) @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || mm0 !== 1'b0 || err0 !== 8'd8) begin
            errors++;
            $display("FAIL stuck_done2: done=%b mm=%b err=%0d want 1/0/8", done0, mm0, err0);
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_jk [8];
        exp_jk = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        pat0 = 8'hA5;
        pv0  = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({j0, k0} !== 2'b01) begin
            errors++;
            $display("FAIL rmid_pre: jk=%b want 01", {j0, k0});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pr0, j0, k0, busy0, done0, mm0} !== 6'b100000 || err0 !== 8'd0 || out0 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: ctrl=%b err=%0d out=%b want 100000/0/0", {pr0, j0, k0, busy0, done0, mm0}, err0, out0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0 || pr0 !== 1'b1) begin
                errors++;
                $display("FAIL rmid_nodone cyc %0d: done=%b ready=%b want 0/1", i, done0, pr0);
            end
        end
        pat0 = 8'h03;
        pv0  = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({j0, k0} !== exp_jk[i]) begin
                errors++;
                $display("FAIL rmid_jk cyc %0d: got %b want %b", i, {j0, k0}, exp_jk[i]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || mm0 !== 1'b0 || err0 !== 8'd0) begin
            errors++;
            $display("FAIL rmid_done: done=%b mm=%b err=%0d want 1/0/0", done0, mm0, err0);
        end
    endtask

    task automatic test_msb_first();
        logic [1:0] exp_jk [8];
        exp_jk = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        pat1 = 8'h80;
        pv1  = 1'b1;
        @(negedge clk);
        pv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({j1, k1} !== exp_jk[i]) begin
                errors++;
                $display("FAIL msb_jk cyc %0d: got %b want %b", i, {j1, k1}, exp_jk[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL msb_drain: done=%b busy=%b want 0/1", done1, busy1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || mm1 !== 1'b0 || err1 !== 8'd0 || out1 !== 1'b0) begin
            errors++;
            $display("FAIL msb_done: done=%b mm=%b err=%0d out=%b want 1/0/0/0", done1, mm1, err1, out1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stuck_fb();
        test_reset_mid();
        test_msb_first();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
